// File: rtl/pong_pkg.sv
// pong_pkg: match states, player encoding and default ball-step timing
// shared between the match scheduler and the ball engine.
package pong_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_SERVE, RALLY, POINT, GAME_OVER} state_t;
   localparam logic P1 = 1'b0;
   localparam logic P2 = 1'b1;
   localparam int PERIOD0_DEF    = 30_000_000;
   localparam int PERIOD1_DEF    = 15_000_000;
   localparam int PERIOD2_DEF    = 8_000_000;
   localparam int PERIOD3_DEF    = 2_000_000;
   localparam int POINT_HOLD_DEF = 25_000_000;
   function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
      return (s >= lim) ? s : s + 4'd1;
   endfunction
endpackage

// File: rtl/pong_tick_div.sv
// pong_tick_div: ball-step divider; the period follows the current speed level and the
// >= compare lets a mid-count speed increase tick at once instead of overrunning.
module pong_tick_div
   import pong_pkg::*;
#(
   parameter int CNT_W   = 26,
   parameter int PERIOD0 = PERIOD0_DEF,
   parameter int PERIOD1 = PERIOD1_DEF,
   parameter int PERIOD2 = PERIOD2_DEF,
   parameter int PERIOD3 = PERIOD3_DEF
) (
   input  logic       CLK50,
   input  logic       RST,
   input  logic       run,
   input  logic       clear,
   input  logic [1:0] speed,
   output logic       tick
);
   logic [CNT_W-1:0] count, last;
   always_comb
      last = (speed == 2'd0) ? CNT_W'(PERIOD0 - 1) :
             (speed == 2'd1) ? CNT_W'(PERIOD1 - 1) :
             (speed == 2'd2) ? CNT_W'(PERIOD2 - 1) : CNT_W'(PERIOD3 - 1);
   always_ff @(posedge CLK50 or posedge RST)
      if (RST) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (clear) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (run && count >= last) begin
         count <= '0;
         tick  <= 1'b1;
      end else begin
         count <= run ? count + 1'b1 : count;
         tick  <= 1'b0;
      end
endmodule

// File: rtl/pong_match_sched.sv
// pong_match_sched: match controller for pong -- serve ownership, scoring, speed level,
// post-point hold and match winner; every output comes straight from a flop.
module pong_match_sched
   import pong_pkg::*;
#(
   parameter int WIN_SCORE  = 11,
   parameter int CNT_W      = 26,
   parameter int PERIOD0    = PERIOD0_DEF,
   parameter int PERIOD1    = PERIOD1_DEF,
   parameter int PERIOD2    = PERIOD2_DEF,
   parameter int PERIOD3    = PERIOD3_DEF,
   parameter int POINT_HOLD = POINT_HOLD_DEF
) (
   input  logic       CLK50,
   input  logic       RST,
   input  logic       enable,
   input  logic [1:0] speed_init,
   input  logic       p1_press,
   input  logic       p2_press,
   input  logic       speed_up,
   input  logic       miss_p1,
   input  logic       miss_p2,
   output logic       ball_tick,
   output logic       serve_go,
   output logic       serve_dir,
   output logic       rally_active,
   output logic [1:0] speed,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       game_over,
   output logic       winner
);
   localparam int HOLD_W = $clog2(POINT_HOLD + 1);
   localparam logic [3:0] WIN = 4'(WIN_SCORE);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POINT_HOLD - 1);
   state_t state, state_n;
   logic [1:0] saved_speed, saved_n, speed_n;
   logic [3:0] score1_n, score2_n;
   logic [HOLD_W-1:0] hold, hold_n;
   logic server_n, go_n;
   // serve_dir doubles as the server register: the serving side always launches away from itself
   always_comb begin
      state_n  = state;
      speed_n  = speed;
      saved_n  = saved_speed;
      server_n = serve_dir;
      score1_n = score1;
      score2_n = score2;
      hold_n   = '0;
      go_n     = 1'b0;
      if (!enable) begin
         state_n  = IDLE;
         speed_n  = '0;
         server_n = P1;
         score1_n = '0;
         score2_n = '0;
      end else
         case (state)
            IDLE: begin
               state_n  = WAIT_SERVE;
               speed_n  = speed_init;
               saved_n  = speed_init;
               server_n = P1;
               score1_n = '0;
               score2_n = '0;
            end
            WAIT_SERVE: begin
               speed_n = saved_speed;
               if ((serve_dir == P2) ? p2_press : p1_press) begin
                  go_n    = 1'b1;
                  state_n = RALLY;
               end
            end
            RALLY:
               if (miss_p1) begin
                  score2_n = sat_inc(score2, WIN);
                  server_n = P1;
                  state_n  = POINT;
               end else if (miss_p2) begin
                  score1_n = sat_inc(score1, WIN);
                  server_n = P2;
                  state_n  = POINT;
               end else if (speed_up && speed != 2'd3)
                  speed_n = speed + 2'd1;
            POINT:
               if (hold == HOLD_LAST)
                  state_n = (score1 == WIN || score2 == WIN) ? GAME_OVER : WAIT_SERVE;
               else
                  hold_n = hold + 1'b1;
            default: ;
         endcase
   end
   always_ff @(posedge CLK50 or posedge RST)
      if (RST) begin
         state        <= IDLE;
         speed        <= '0;
         saved_speed  <= '0;
         serve_dir    <= P1;
         score1       <= '0;
         score2       <= '0;
         hold         <= '0;
         serve_go     <= 1'b0;
         rally_active <= 1'b0;
         game_over    <= 1'b0;
         winner       <= 1'b0;
      end else begin
         state        <= state_n;
         speed        <= speed_n;
         saved_speed  <= saved_n;
         serve_dir    <= server_n;
         score1       <= score1_n;
         score2       <= score2_n;
         hold         <= hold_n;
         serve_go     <= go_n;
         rally_active <= state_n == RALLY;
         game_over    <= state_n == GAME_OVER;
         winner       <= state_n == GAME_OVER && score2_n == WIN;
      end
   pong_tick_div #(
      .CNT_W(CNT_W), .PERIOD0(PERIOD0), .PERIOD1(PERIOD1), .PERIOD2(PERIOD2), .PERIOD3(PERIOD3)
   ) u_div (
      .CLK50(CLK50),
      .RST(RST),
      .run(state == RALLY),
      .clear(state_n != RALLY),
      .speed(speed),
      .tick(ball_tick)
   );
endmodule

// File: tb/tb_pong_match_sched.sv
// tb_pong_match_sched: directed checks of serve, speed, scoring, hold and reset behaviour
// with short periods 8/6/4/2, POINT_HOLD=3 and WIN_SCORE=3.
module tb_pong_match_sched;
   logic CLK50 = 1'b0;
   logic RST, enable, p1_press, p2_press, speed_up, miss_p1, miss_p2;
   logic [1:0] speed_init, speed;
   logic ball_tick, serve_go, serve_dir, rally_active, game_over, winner;
   logic [3:0] score1, score2;
   logic [15:0] outs;
   int checks = 0;
   int failures = 0;
   int n;
   always #5 CLK50 = ~CLK50;
   assign outs = {ball_tick, serve_go, serve_dir, rally_active, speed, score1, score2, game_over, winner};
   pong_match_sched #(
      .WIN_SCORE(3), .CNT_W(8), .PERIOD0(8), .PERIOD1(6), .PERIOD2(4), .PERIOD3(2), .POINT_HOLD(3)
   ) dut (
      .CLK50(CLK50), .RST(RST), .enable(enable), .speed_init(speed_init),
      .p1_press(p1_press), .p2_press(p2_press), .speed_up(speed_up),
      .miss_p1(miss_p1), .miss_p2(miss_p2), .ball_tick(ball_tick), .serve_go(serve_go),
      .serve_dir(serve_dir), .rally_active(rally_active), .speed(speed), .score1(score1),
      .score2(score2), .game_over(game_over), .winner(winner)
   );
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic step(input int k);
      repeat (k) @(posedge CLK50);
      #1;
   endtask
   task automatic wait_tick(output int cyc);
      cyc = 0;
      do begin
         step(1);
         cyc++;
      end while (!ball_tick && cyc < 40);
   endtask
   initial begin
      RST = 1'b1; enable = 1'b0; speed_init = 2'd0;
      p1_press = 1'b0; p2_press = 1'b0; speed_up = 1'b0; miss_p1 = 1'b0; miss_p2 = 1'b0;
      step(2);
      check("reset_outs", outs, 0);
      RST = 1'b0; enable = 1'b1; speed_init = 2'd2;
      step(1);
      check("idle_exit_speed", speed, 2);
      // serve ownership and first ticks at speed 2
      p2_press = 1'b1; step(1); p2_press = 1'b0;
      check("p2_ignored_go", serve_go, 0);
      check("p2_ignored_rally", rally_active, 0);
      p1_press = 1'b1; step(1); p1_press = 1'b0;
      check("serve_go", serve_go, 1);
      check("serve_dir_p1", serve_dir, 0);
      check("rally_active", rally_active, 1);
      wait_tick(n);
      check("first_tick_s2", n, 4);
      wait_tick(n);
      check("second_tick_s2", n, 4);
      // point to P1, hold, then P2 serves at restored speed
      speed_up = 1'b1; step(1); speed_up = 1'b0;
      check("speed_up_3", speed, 3);
      miss_p2 = 1'b1; step(1); miss_p2 = 1'b0;
      check("miss_p2_score1", score1, 1);
      check("miss_p2_score2", score2, 0);
      check("server_p2", serve_dir, 1);
      check("point_not_rally", rally_active, 0);
      step(1);
      check("point_no_tick1", ball_tick, 0);
      step(1);
      check("point_no_tick2", ball_tick, 0);
      p2_press = 1'b1; step(1); p2_press = 1'b0;
      check("press_during_hold", serve_go, 0);
      p1_press = 1'b1; step(1); p1_press = 1'b0;
      check("wrong_server_press", serve_go, 0);
      p2_press = 1'b1; step(1); p2_press = 1'b0;
      check("p2_serve_go", serve_go, 1);
      check("p2_serve_dir", serve_dir, 1);
      check("speed_restored", speed, 2);
      // simultaneous misses plus speed_up
      miss_p1 = 1'b1; miss_p2 = 1'b1; speed_up = 1'b1; step(1);
      miss_p1 = 1'b0; miss_p2 = 1'b0; speed_up = 1'b0;
      check("dual_miss_score2", score2, 1);
      check("dual_miss_score1", score1, 1);
      check("dual_miss_speed", speed, 2);
      check("dual_miss_server", serve_dir, 0);
      enable = 1'b0; step(1);
      check("disable_clear", outs, 0);
      // new match at speed 0: speed ramp and mid-count speed change
      speed_init = 2'd0; enable = 1'b1; step(1);
      check("matchB_speed", speed, 0);
      p1_press = 1'b1; step(1); p1_press = 1'b0;
      check("matchB_serve", serve_go, 1);
      speed_up = 1'b1; step(1); speed_up = 1'b0;
      check("ramp_1", speed, 1);
      step(3);
      check("no_tick_count4", ball_tick, 0);
      speed_up = 1'b1; step(1); speed_up = 1'b0;
      check("ramp_2", speed, 2);
      check("no_tick_count5", ball_tick, 0);
      step(1);
      check("overrun_tick", ball_tick, 1);
      speed_up = 1'b1; step(1); speed_up = 1'b0;
      check("ramp_3", speed, 3);
      check("no_tick_after_ramp3", ball_tick, 0);
      speed_up = 1'b1; step(1); speed_up = 1'b0;
      check("ramp_sat", speed, 3);
      check("tick_at_speed3", ball_tick, 1);
      wait_tick(n);
      check("period_speed3", n, 2);
      // three points to P2 ends the match
      for (int k = 1; k <= 3; k++) begin
         miss_p1 = 1'b1; step(1); miss_p1 = 1'b0;
         check("miss_p1_score2", score2, k);
         check("miss_p1_server", serve_dir, 0);
         step(3);
         if (k < 3) begin
            check("not_over_yet", game_over, 0);
            p1_press = 1'b1; step(1); p1_press = 1'b0;
            check("reserve_go", serve_go, 1);
         end else begin
            check("game_over", game_over, 1);
            check("winner_p2", winner, 1);
         end
      end
      p1_press = 1'b1; p2_press = 1'b1; miss_p1 = 1'b1; miss_p2 = 1'b1; speed_up = 1'b1;
      step(2);
      p1_press = 1'b0; p2_press = 1'b0; miss_p1 = 1'b0; miss_p2 = 1'b0; speed_up = 1'b0;
      check("frozen_score2", score2, 3);
      check("frozen_score1", score1, 0);
      check("frozen_over", game_over, 1);
      check("frozen_go", serve_go, 0);
      enable = 1'b0; step(1);
      check("over_clear", outs, 0);
      // asynchronous reset mid-rally
      speed_init = 2'd1; enable = 1'b1; step(1);
      p1_press = 1'b1; step(1); p1_press = 1'b0;
      step(2);
      check("pre_reset_rally", rally_active, 1);
      check("pre_reset_speed", speed, 1);
      #3 RST = 1'b1;
      #1 check("async_reset_outs", outs, 0);
      step(1);
      RST = 1'b0;
      step(1);
      check("post_reset_idle_exit", speed, 1);
      check("post_reset_no_rally", rally_active, 0);
      check("post_reset_no_go", serve_go, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pong_match_sched.md
Name: pong_match_sched

Overview:
- Match-level controller that sequences the pong ball engine.
- Enforces serve ownership: the loser of each point serves next.
- Generates the ball-step tick at a rate set by the current speed level, and raises speed on inner-paddle hits.
- Keeps both scores, holds briefly after each point, and declares the match winner.
- Sits between the button press detectors / switches and the ball-position/LED datapath. Its scores feed the HEX display decoders.

Parameters:
- WIN_SCORE, 11: points needed to win; must be ≤15.
- CNT_W, 26: width of the tick divider counter.
- PERIOD0, 30_000_000: ball-step period in cycles at speed 0 (slow).
- PERIOD1, 15_000_000: period at speed 1.
- PERIOD2, 8_000_000: period at speed 2.
- PERIOD3, 2_000_000: period at speed 3 (fastest).
- POINT_HOLD, 25_000_000: cycles the POINT state holds before the next serve or game over.

Ports:
- CLK50  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- enable  in  1  match enable (run switch). Low means synchronous clear to IDLE.
- speed_init  in  2  starting speed level; sampled on leaving IDLE.
- p1_press  in  1  single-cycle press pulse, player 1.
- p2_press  in  1  single-cycle press pulse, player 2.
- speed_up  in  1  pulse from ball engine on an inner-paddle return.
- miss_p1  in  1  pulse from ball engine: ball passed player 1.
- miss_p2  in  1  pulse from ball engine: ball passed player 2.
- ball_tick  out  1  one-cycle pulse, step the ball one position.
- serve_go  out  1  one-cycle pulse, launch ball from the server's end.
- serve_dir  out  1  0 = toward P2 (P1 serving); 1 = toward P1.
- rally_active  out  1  high only in RALLY.
- speed  out  2  current speed level.
- score1  out  4  player 1 score.
- score2  out  4  player 2 score.
- game_over  out  1  high in GAME_OVER.
- winner  out  1  0 = P1, 1 = P2; valid only while game_over is high.

Behaviour:
- On RST: state=IDLE; all outputs 0; saved_speed=0; server=P1; divider count=0; hold count=0.
- enable=0 in any state: next edge forces IDLE and clears scores, speed, server (to P1), and both counters. All pulse outputs are 0 that cycle.
- IDLE: on enable=1, latch speed_init into speed and saved_speed, set server=P1, go to WAIT_SERVE.
- WAIT_SERVE:
  - speed is reloaded from saved_speed.
  - Only the current server's press is accepted; the other player's press is ignored.
  - On an accepted press at edge t: serve_go=1 and serve_dir=server during cycle t+1, divider is cleared, state becomes RALLY.
- RALLY:
  - ball_tick pulses every PERIODn cycles; the first tick occurs exactly PERIODn cycles after serve_go.
  - speed_up raises speed by 1, saturating at 3.
  - miss_p1: score2+1, server=P1, go to POINT.
  - miss_p2: score1+1, server=P2, go to POINT.
  - All presses are ignored.
- Simultaneous events in RALLY:
  - miss_p1 has priority over miss_p2; the lower-priority miss is dropped.
  - speed_up in the same cycle as any miss is dropped.
- POINT:
  - ball_tick is suppressed and presses are ignored.
  - The hold counter runs POINT_HOLD cycles.
  - Then, if score1==WIN_SCORE or score2==WIN_SCORE, go to GAME_OVER; otherwise go to WAIT_SERVE.
- GAME_OVER:
  - game_over=1; winner = the side that reached WIN_SCORE.
  - Scores are frozen; all inputs except enable are ignored.
  - Exit only via enable=0 or RST.
- Divider:
  - Counter increments each RALLY cycle.
  - When count ≥ period(speed)−1, it emits ball_tick and wraps to 0.
  - The ≥ compare makes a mid-count speed increase tick on the next cycle rather than overrun.
  - Counter is held at 0 outside RALLY.
- Widths and registration:
  - Scores saturate at WIN_SCORE; they never wrap.
  - All outputs are registered. No combinational path runs from any input to any output.

Decomposition:
- Shared package pong_pkg contains:
  - state enum {IDLE, WAIT_SERVE, RALLY, POINT, GAME_OVER};
  - player encoding P1=0, P2=1;
  - default speed period constants, shared with the ball engine.
- One sub-module, pong_tick_div:
  - ports: clock, reset, run, clear, speed (2), tick;
  - contains the period mux and the CNT_W counter.

Test Plan:
All scenarios use bench parameters PERIOD0..3=8,6,4,2; POINT_HOLD=3; WIN_SCORE=3.
1. RST, enable=1, speed_init=2, p2_press → stays WAIT_SERVE, no serve_go. Then p1_press at t → serve_go=1 and serve_dir=0 at t+1; first ball_tick 4 cycles later, then every 4 cycles.
2. In RALLY at speed 0, speed_up ×4 → speed reads 1, 2, 3, 3. Speed_up issued with 5 counts elapsed → ball_tick next cycle (5 ≥ 3); the following period is 2 cycles.
3. miss_p2 → score1=1, POINT held 3 cycles with no ticks, then WAIT_SERVE with server=P2. p1_press ignored; p2_press → serve_dir=1, speed restored to speed_init.
4. miss_p1 and miss_p2 in the same cycle together with speed_up → only score2 increments; speed unchanged; server=P1.
5. Three miss_p1 events → score2=3, game_over=1, winner=1. Further presses and misses change nothing. enable=0 → next cycle IDLE with score1=score2=0 and game_over=0.
6. Assert RST mid-RALLY asynchronously → all outputs 0 immediately, with no clock edge required; after release, IDLE.
